// File: rtl/jsilicon_pkg.sv
// Shared definitions for the JSilicon accumulator core:
// opcodes, FSM states and instruction field helpers.
package jsilicon_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Widest instruction the slicing helpers accept.
    localparam int MAX_IW = 64;

    typedef enum logic [1:0] {
        HALT,
        FETCH,
        EXEC,
        OUT_WAIT
    } state_t;

    function automatic logic [3:0] f_op(
        logic [MAX_IW-1:0] ins, int rw, int dw);
        return ins[rw+dw +: 4];
    endfunction

    function automatic logic [31:0] f_rd(
        logic [MAX_IW-1:0] ins, int rw, int dw);
        logic [31:0] m;
        m = (32'd1 << rw) - 32'd1;
        return 32'(ins >> dw) & m;
    endfunction

    function automatic logic [MAX_IW-1:0] f_field(
        logic [MAX_IW-1:0] ins, int dw);
        logic [MAX_IW-1:0] m;
        m = (64'd1 << dw) - 64'd1;
        return ins & m;
    endfunction

endpackage

// File: rtl/jsilicon_if.sv
// Result port towards the UART transmitter:
// valid/ready handshake carrying one data word.
interface jsilicon_if #(
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/jsilicon_alu.sv
// Combinational ALU for opcodes ADD..SHR; other opcodes
// produce zero result and no carry.
module jsilicon_alu
    import jsilicon_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    logic [DATA_W:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            // Top bit of the extended difference is the borrow.
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: ;
        endcase
        zero = (result == '0);
    end
endmodule

// File: rtl/jsilicon_cpu.sv
// Multi-cycle accumulator CPU with loadable program memory,
// branches, halt/single-step and a valid/ready result port.
module jsilicon_cpu
    import jsilicon_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NREGS      = 4,
    parameter  int PROG_DEPTH = 16,
    localparam int RW         = $clog2(NREGS),
    localparam int AW         = $clog2(PROG_DEPTH),
    localparam int INSTR_W    = 4 + RW + DATA_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ena,
    input  logic               start,
    input  logic               step_mode,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    jsilicon_if.master         res,
    output logic               halted,
    output logic [AW-1:0]      pc,
    output logic               zero_flag,
    output logic               carry_flag,
    input  logic [RW-1:0]      dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);
    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] mem  [PROG_DEPTH];
    logic [DATA_W-1:0]  regs [NREGS];

    logic [3:0]        op;
    logic [RW-1:0]     rd;
    logic [RW-1:0]     rs;
    logic [DATA_W-1:0] field;
    logic [AW-1:0]     tgt;
    logic [AW-1:0]     pc_inc;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_zero;

    assign op     = f_op(MAX_IW'(ir), RW, DATA_W);
    assign rd     = RW'(f_rd(MAX_IW'(ir), RW, DATA_W));
    assign field  = DATA_W'(f_field(MAX_IW'(ir), DATA_W));
    assign rs     = field[RW-1:0];
    assign tgt    = field[AW-1:0];
    assign pc_inc = pc + AW'(1);

    assign dbg_data = regs[dbg_sel];

    jsilicon_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (regs[rd]),
        .b      (regs[rs]),
        .result (alu_res),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Memory is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (!reset && ena && state == HALT && load_en)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= HALT;
            halted        <= 1'b1;
            pc            <= '0;
            ir            <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            res.out_valid <= 1'b0;
            res.out_data  <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (ena) begin
            unique case (state)
                HALT: begin
                    if (start) begin
                        state  <= FETCH;
                        halted <= 1'b0;
                    end
                end
                FETCH: begin
                    ir    <= mem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    pc     <= pc_inc;
                    state  <= step_mode ? HALT : FETCH;
                    halted <= step_mode;
                    case (op)
                        OP_LDI: regs[rd] <= field;
                        OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_XOR, OP_SHL, OP_SHR: begin
                            regs[rd]   <= alu_res;
                            zero_flag  <= alu_zero;
                            carry_flag <= alu_carry;
                        end
                        // pc advances only once the word is taken.
                        OP_OUT: begin
                            pc            <= pc;
                            res.out_valid <= 1'b1;
                            res.out_data  <= regs[rd];
                            state         <= OUT_WAIT;
                            halted        <= 1'b0;
                        end
                        OP_JMP: pc <= tgt;
                        OP_JZ: begin
                            if (regs[rd] == '0)
                                pc <= tgt;
                        end
                        OP_HLT: begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                OUT_WAIT: begin
                    if (res.out_ready) begin
                        res.out_valid <= 1'b0;
                        pc            <= pc_inc;
                        state         <= step_mode ? HALT : FETCH;
                        halted        <= step_mode;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jsilicon_cpu.sv
// Directed bench for jsilicon_cpu: arithmetic, flags, branches,
// result backpressure, single-step and reset during output.
module tb_jsilicon_cpu;
    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        start;
    logic        step_mode;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [13:0] load_data;
    logic        halted;
    logic [3:0]  pc;
    logic        zf;
    logic        cf;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jsilicon_if #(.DATA_W(8)) bus ();

    jsilicon_cpu #(
        .DATA_W     (8),
        .NREGS      (4),
        .PROG_DEPTH (16)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .ena        (ena),
        .start      (start),
        .step_mode  (step_mode),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .res        (bus),
        .halted     (halted),
        .pc         (pc),
        .zero_flag  (zf),
        .carry_flag (cf),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    function automatic logic [13:0] ins(
        logic [3:0] op, logic [1:0] rd, logic [7:0] f);
        return {op, rd, f};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic reg_is(input logic [1:0] r,
                          input logic [7:0] v,
                          input string tag);
        dbg_sel = r;
        #1;
        chk(tag, 32'(dbg_data), 32'(v));
    endtask

    task automatic ld(input logic [3:0] a, input logic [13:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go(input logic wl,
                      input logic [3:0] a,
                      input logic [13:0] d);
        @(negedge clk);
        start     = 1'b1;
        load_en   = wl;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic run(input int budget,
                       output int outs,
                       output logic [7:0] last);
        outs = 0;
        last = '0;
        for (int i = 0; i < budget && !halted; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                outs++;
                last = bus.out_data;
            end
        end
        chk("halt_timeout", 32'(halted), 1);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !bus.out_valid; i++)
            @(negedge clk);
        chk("valid_timeout", 32'(bus.out_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         outs;
        int         vcnt;
        int         hcyc;
        logic [7:0] last;
        logic [7:0] vdata;
        logic       stable;

        rst           = 1'b1;
        ena           = 1'b1;
        start         = 1'b0;
        step_mode     = 1'b0;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        dbg_sel       = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_halted", 32'(halted), 1);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_flags", 32'({zf, cf}), 0);
        for (int r = 0; r < 4; r++)
            reg_is(2'(r), 8'h00, "rst_reg");
        rst = 1'b0;

        // LDI/LDI/ADD/OUT/HLT with cycle-exact timing
        ld(4'd0, ins(4'h1, 2'd0, 8'd5));
        ld(4'd1, ins(4'h1, 2'd1, 8'd3));
        ld(4'd2, ins(4'h2, 2'd0, 8'd1));
        ld(4'd3, ins(4'h9, 2'd0, 8'd0));
        ld(4'd4, ins(4'hF, 2'd0, 8'd0));
        go(1'b0, 4'd0, 14'd0);
        chk("halted_drop", 32'(halted), 0);
        vcnt  = 0;
        hcyc  = 0;
        vdata = '0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                vcnt++;
                vdata = bus.out_data;
            end
            if (halted && hcyc == 0)
                hcyc = cyc;
        end
        chk("add_valid_cycles", 32'(vcnt), 1);
        chk("add_out_data", 32'(vdata), 8);
        chk("add_halt_cycle", 32'(hcyc), 11);
        chk("add_pc", 32'(pc), 5);
        chk("add_flags", 32'({zf, cf}), 0);
        reg_is(2'd0, 8'd8, "add_r0");

        // SUB with borrow
        do_reset();
        ld(4'd0, ins(4'h1, 2'd0, 8'd2));
        ld(4'd1, ins(4'h1, 2'd1, 8'd3));
        ld(4'd2, ins(4'h3, 2'd0, 8'd1));
        ld(4'd3, ins(4'hF, 2'd0, 8'd0));
        go(1'b0, 4'd0, 14'd0);
        run(50, outs, last);
        reg_is(2'd0, 8'hFF, "sub_borrow_r0");
        chk("sub_borrow_cf", 32'(cf), 1);
        chk("sub_borrow_zf", 32'(zf), 0);

        // SUB to zero
        do_reset();
        ld(4'd0, ins(4'h1, 2'd0, 8'd3));
        go(1'b0, 4'd0, 14'd0);
        run(50, outs, last);
        reg_is(2'd0, 8'h00, "sub_zero_r0");
        chk("sub_zero_zf", 32'(zf), 1);
        chk("sub_zero_cf", 32'(cf), 0);

        // countdown loop with JZ/JMP
        do_reset();
        ld(4'd0, ins(4'h1, 2'd1, 8'd1));
        ld(4'd1, ins(4'h1, 2'd0, 8'd3));
        ld(4'd2, ins(4'h3, 2'd0, 8'd1));
        ld(4'd3, ins(4'hB, 2'd0, 8'd6));
        ld(4'd4, ins(4'hA, 2'd0, 8'd2));
        ld(4'd5, ins(4'h0, 2'd0, 8'd0));
        ld(4'd6, ins(4'h9, 2'd0, 8'd0));
        ld(4'd7, ins(4'hF, 2'd0, 8'd0));
        go(1'b0, 4'd0, 14'd0);
        run(200, outs, last);
        chk("loop_out_count", 32'(outs), 1);
        chk("loop_out_data", 32'(last), 0);
        chk("loop_pc", 32'(pc), 8);

        // backpressure on the result port
        do_reset();
        ld(4'd0, ins(4'h1, 2'd2, 8'hA5));
        ld(4'd1, ins(4'h9, 2'd2, 8'd0));
        ld(4'd2, ins(4'hF, 2'd0, 8'd0));
        bus.out_ready = 1'b0;
        go(1'b0, 4'd0, 14'd0);
        wait_valid(20);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(bus.out_valid && bus.out_data == 8'hA5 && pc == 4'd1))
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 1);
        chk("bp_data", 32'(bus.out_data), 'hA5);
        chk("bp_pc_hold", 32'(pc), 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_fall", 32'(bus.out_valid), 0);
        chk("bp_pc_adv", 32'(pc), 2);
        run(20, outs, last);
        chk("bp_end_pc", 32'(pc), 3);

        // single-step, with a load attempted during FETCH
        do_reset();
        ld(4'd0, ins(4'h1, 2'd0, 8'd7));
        ld(4'd1, ins(4'h1, 2'd1, 8'd9));
        ld(4'd2, ins(4'h2, 2'd0, 8'd1));
        ld(4'd3, ins(4'hF, 2'd0, 8'd0));
        step_mode = 1'b1;
        go(1'b0, 4'd0, 14'd0);
        run(10, outs, last);
        chk("step1_pc", 32'(pc), 1);
        reg_is(2'd0, 8'd7, "step1_r0");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        load_en   = 1'b1;
        load_addr = 4'd2;
        load_data = ins(4'h1, 2'd0, 8'h33);
        @(negedge clk);
        load_en = 1'b0;
        run(10, outs, last);
        chk("step2_pc", 32'(pc), 2);
        reg_is(2'd1, 8'd9, "step2_r1");
        go(1'b0, 4'd0, 14'd0);
        run(10, outs, last);
        chk("step3_pc", 32'(pc), 3);
        reg_is(2'd0, 8'h10, "step3_r0");
        ena = 1'b0;
        go(1'b0, 4'd0, 14'd0);
        @(negedge clk);
        chk("ena_hold_halted", 32'(halted), 1);
        chk("ena_hold_pc", 32'(pc), 3);
        ena       = 1'b1;
        step_mode = 1'b0;

        // reset while a result is pending
        do_reset();
        ld(4'd0, ins(4'h1, 2'd3, 8'h3C));
        ld(4'd1, ins(4'h9, 2'd3, 8'd0));
        ld(4'd2, ins(4'hF, 2'd0, 8'd0));
        bus.out_ready = 1'b0;
        go(1'b0, 4'd0, 14'd0);
        wait_valid(20);
        rst = 1'b1;
        @(negedge clk);
        chk("rstow_valid", 32'(bus.out_valid), 0);
        chk("rstow_halted", 32'(halted), 1);
        chk("rstow_pc", 32'(pc), 0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        // start together with a load of the word about to be fetched
        go(1'b1, 4'd0, ins(4'h1, 2'd3, 8'h5A));
        run(50, outs, last);
        chk("rerun_out_count", 32'(outs), 1);
        chk("rerun_out_data", 32'(last), 'h5A);
        chk("rerun_pc", 32'(pc), 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/jsilicon_cpu.md
# jsilicon_cpu

Parametrised successor to the two-register JSilicon core. It is a multi-cycle accumulator-style CPU with a configurable data width, register-file size and program depth. Program memory is writable from outside through a load port. Added over the previous core: branches, a halt state, single-step mode and a valid/ready result port that drives the UART path. It sits between the pad-level top (which keeps the manual/CPU mode mux) and the UART transmitter.

## Interface
- DATA_W, 8, datapath and register width (≥4)
- NREGS, 4, register count (power of two, ≥2); RW = clog2(NREGS)
- PROG_DEPTH, 16, program words (power of two); AW = clog2(PROG_DEPTH)
- INSTR_W (derived), 4+RW+DATA_W, instruction = {op[3:0], rd[RW-1:0], field[DATA_W-1:0]}
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ena  in  1  clock enable; when low, all state (FSM, PC, regs, flags, memory writes) holds
- start  in  1  pulse; leave HALT and run from current pc
- step_mode  in  1  level; return to HALT after every retired instruction
- load_en  in  1  program-memory write strobe (honoured only in HALT)
- load_addr  in  AW  write address
- load_data  in  INSTR_W  write data
- out_valid  out  1  result word available
- out_data  out  DATA_W  result word (stable while out_valid)
- out_ready  in  1  consumer (UART) accepts
- halted  out  1  FSM in HALT
- pc  out  AW  program counter
- zero_flag / carry_flag  out  1  ALU flags
- dbg_sel  in  RW, dbg_data  out  DATA_W  combinational register peek

## Operation
- Reset: state=HALT, pc=0, all regs=0, flags=0, out_valid=0, out_data=0, halted=1. Program memory is not cleared.
- FSM states and transitions:
  - HALT→FETCH on start.
  - FETCH→EXEC: latch mem[pc].
  - EXEC→FETCH for ordinary instructions, →OUT_WAIT for OUT, →HALT for HLT, or →HALT if step_mode=1.
  - OUT_WAIT→FETCH, or →HALT if step_mode=1, on out_valid & out_ready.
- Opcodes. rs = field[RW-1:0], tgt = field[AW-1:0].
  - 0 NOP.
  - 1 LDI: rd ← field.
  - 2 ADD: rd ← rd+rs.
  - 3 SUB: rd ← rd−rs.
  - 4 AND, 5 OR, 6 XOR.
  - 7 SHL: rd ← rd<<1.
  - 8 SHR: rd ← rd>>1, logical.
  - 9 OUT: out_data ← rd.
  - A JMP: pc ← tgt.
  - B JZ: if rd==0 then pc ← tgt.
  - F HLT.
  - C–E: treated as NOP.
- Arithmetic is modulo 2^DATA_W.
  - ADD: carry = bit DATA_W of the sum.
  - SUB: carry = borrow (rd<rs).
  - SHL: carry = MSB shifted out. SHR: carry = LSB shifted out.
  - zero_flag = (result==0). Flags update only on opcodes 2–8.
- pc increments modulo PROG_DEPTH, so PROG_DEPTH−1 wraps to 0. JMP/JZ override the increment. HLT leaves pc at the HLT address + 1.
- load_en outside HALT is ignored. load_en together with start in HALT: the write commits and the start is accepted; the following FETCH reads the new word.
- start outside HALT is ignored.
- Reset in any state, including OUT_WAIT with out_valid high, drops out_valid the same edge and returns to HALT.

## Timing
- Non-OUT instruction: 2 cycles (FETCH, EXEC). Register and flag write at the end of EXEC.
- OUT: out_valid rises at the end of EXEC. The handshake completes on the first cycle with out_valid & out_ready; out_valid falls on the next edge.
  - Minimum OUT cost is 3 cycles.
  - out_data is stable for the whole time out_valid is high.
- halted is registered from the state. It goes low 1 cycle after start.
- dbg_data is combinational from dbg_sel.

## Structure
- Shared package jsilicon_pkg holds:
  - opcode localparams (OP_NOP…OP_HLT);
  - the FSM state enum {HALT, FETCH, EXEC, OUT_WAIT};
  - instruction field slicing functions parametrised by RW/DATA_W.
- Sub-module jsilicon_alu is combinational. It is parametrised by DATA_W, takes (op, a, b) and returns result, carry and zero.
- Program memory is an inline register array with a synchronous write and a registered read in FETCH.

## Test plan
- Reset then start with LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HLT. Hold out_ready=1. Required:
  - out_data=8 with out_valid high for 1 cycle;
  - halted=1 at cycle 11 after start;
  - pc=5.
- Run SUB with r0=2, r1=3 → r0=0xFF, carry_flag=1, zero_flag=0. Run SUB with r0=3, r1=3 → zero_flag=1, carry_flag=0.
- Countdown loop LDI r0,3; SUB r0,r1 (r1=1); JZ r0,5; JMP 1; at address 5 OUT r0; HLT → exactly one out_data=0.
- Hold out_ready low for 5 cycles during OUT. Required:
  - out_valid stays high with data stable;
  - pc is unchanged;
  - release → pc advances 1 cycle after acceptance.
- step_mode=1. Required:
  - each start pulse retires exactly one instruction;
  - load_en during FETCH does not alter memory (read back via a later run).
- Assert reset during OUT_WAIT → out_valid=0, halted=1, pc=0 next cycle. The program still runs correctly after start.
